// File: rtl/maxpool_layer_2_pkg.sv
// Shared constants and types for the second 2x2 max-pool stage.
package maxpool_layer_2_pkg;

  localparam int CNN_DATA_WIDTH     = 16;
  localparam int CONV2_OUT_CHANNELS = 3;
  localparam int CONV2_OUT_IMG_SIZE = 10;
  localparam int POOL2_OUT_SIZE     = CONV2_OUT_IMG_SIZE / 2;
  localparam int OUT_IDX_WIDTH      = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_t;

  // Counter width able to hold 0..n-1, never narrower than min_w.
  function automatic int field_width(input int n, input int min_w);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/maxpool_layer_2_signed_max2.sv
// Combinational two-input signed maximum; equal inputs return a.
module signed_max2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  // Two's-complement comparison of the raw sample words.
  always_comb begin
    y = ($signed(a) >= $signed(b)) ? a : b;
  end

endmodule

// File: rtl/maxpool_layer_2.sv
// 2x2 stride-2 streaming max-pool over a channel-major raster stream,
// using one line buffer of horizontal maxima from each even row.
module maxpool_layer_2
  import maxpool_layer_2_pkg::*;
#(
  parameter int CHANNELS    = CONV2_OUT_CHANNELS,
  parameter int IN_IMG_SIZE = CONV2_OUT_IMG_SIZE,
  parameter int POOL_SIZE   = 2,
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_pool2,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [6:0]            out_idx,
  output logic                  busy,
  output logic                  finish_pool2
);

  localparam int OUT_IMG_SIZE = IN_IMG_SIZE / 2;
  localparam int COL_W        = field_width(IN_IMG_SIZE, 2);
  localparam int ROW_W        = field_width(IN_IMG_SIZE, 1);
  localparam int CH_W         = field_width(CHANNELS, 1);
  localparam int LB_W         = COL_W - 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_IMG_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_IMG_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  if (IN_IMG_SIZE % 2 != 0) begin : g_bad_img_size
    $error("maxpool_layer_2: IN_IMG_SIZE must be even");
  end
  if (POOL_SIZE != 2) begin : g_bad_pool_size
    $error("maxpool_layer_2: only POOL_SIZE = 2 is supported");
  end

  pool_state_t state_q, state_d;

  logic [COL_W-1:0]         col_q;
  logic [ROW_W-1:0]         row_q;
  logic [CH_W-1:0]          ch_q;
  logic [OUT_IDX_WIDTH-1:0] out_cnt_q;
  logic [DATA_WIDTH-1:0]    hold_q;
  logic [DATA_WIDTH-1:0]    linebuf_q [OUT_IMG_SIZE];

  logic                  accept;
  logic                  start_accept;
  logic                  col_last, row_last, ch_last;
  logic                  last_pixel;
  logic                  window_done;
  logic [LB_W-1:0]       lb_addr;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] vmax;

  // Handshake qualifiers and window position decode.
  always_comb begin
    accept       = (state_q == ST_RUN) && in_valid;
    start_accept = (state_q == ST_IDLE) && start_pool2;
    col_last     = (col_q == COL_LAST);
    row_last     = (row_q == ROW_LAST);
    ch_last      = (ch_q == CH_LAST);
    last_pixel   = accept && ch_last && row_last && col_last;
    window_done  = accept && col_q[0] && row_q[0];
    lb_addr      = col_q[COL_W-1:1];
    lb_rd        = linebuf_q[lb_addr];
  end

  signed_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (
    .a (hold_q),
    .b (in_data),
    .y (hmax)
  );

  signed_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (
    .a (lb_rd),
    .b (hmax),
    .y (vmax)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (start_pool2) state_d = ST_RUN;
      ST_RUN:  if (last_pixel)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster position counters: col, then row, then channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (start_accept) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        if (row_last) begin
          row_q <= '0;
          ch_q  <= ch_last ? '0 : ch_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Left pixel of each horizontal pair, held until its right partner arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else if (accept && !col_q[0]) begin
      hold_q <= in_data;
    end
  end

  // Even-row horizontal maxima, consumed by the odd row below them.
  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0]) begin
      linebuf_q[lb_addr] <= hmax;
    end
  end

  // Registered result, index and completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      out_cnt_q    <= '0;
      finish_pool2 <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      finish_pool2 <= (state_q == ST_DONE);
      if (start_accept) begin
        out_cnt_q <= '0;
      end else if (window_done) begin
        out_valid <= 1'b1;
        out_data  <= vmax;
        out_idx   <= out_cnt_q;
        out_cnt_q <= out_cnt_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer_2.sv
// Directed bench for maxpool_layer_2 with a reference pooled-image model.
module tb_maxpool_layer_2;

  localparam int C     = 3;
  localparam int N     = 10;
  localparam int O     = 5;
  localparam int TOTAL = C * O * O;
  localparam int NPIX  = C * N * N;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_pool2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [6:0]  out_idx;
  logic        busy;
  logic        finish_pool2;

  always #5 clk = ~clk;

  maxpool_layer_2 #(
    .CHANNELS    (C),
    .IN_IMG_SIZE (N),
    .POOL_SIZE   (2),
    .DATA_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_pool2  (start_pool2),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .busy         (busy),
    .finish_pool2 (finish_pool2)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] img     [NPIX];
  logic signed [15:0] exp_val [TOTAL];
  logic signed [15:0] got     [TOTAL];
  int   exp_n     = 0;
  int   fin_cnt   = 0;
  logic prev_last = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Pooled image straight from the definition of a 2x2 window maximum.
  task automatic build_model();
    for (int ch = 0; ch < C; ch++)
      for (int r = 0; r < O; r++)
        for (int c = 0; c < O; c++) begin
          int base;
          base = ch * N * N + 2 * r * N + 2 * c;
          exp_val[ch * O * O + r * O + c] =
            smax(smax(img[base], img[base + 1]), smax(img[base + N], img[base + N + 1]));
        end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = 16'(i);
  endtask

  // Output checker: every result in order against the model, finish timing.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last = 1'b0;
    end else begin
      if (prev_last || finish_pool2)
        check("finish_after_idx74", finish_pool2, prev_last);
      prev_last = out_valid && (out_idx == 7'd74);
      if (finish_pool2) fin_cnt++;
      if (out_valid) begin
        if (exp_n >= TOTAL) begin
          checks++;
          failures++;
          $display("FAIL extra_output actual_idx=%0d required=none", out_idx);
        end else begin
          check("out_data", $signed(out_data), exp_val[exp_n]);
          check("out_idx", out_idx, exp_n);
          got[exp_n] = out_data;
          exp_n++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    build_model();
    exp_n       = 0;
    start_pool2 = 1'b1;
    tick();
    start_pool2 = 1'b0;
  endtask

  task automatic stream(input int n, input int gap_pct, input int pulse_at);
    int i;
    bit pulsed;
    i      = 0;
    pulsed = 0;
    while (i < n) begin
      if (i == pulse_at && !pulsed) begin
        in_valid    = 1'b0;
        start_pool2 = 1'b1;
        pulsed      = 1;
        tick();
        start_pool2 = 1'b0;
      end else begin
        if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = img[i];
          i++;
        end
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int f0;
    int c;
    f0 = fin_cnt;
    c  = 0;
    while (fin_cnt == f0 && c < 500) begin
      tick();
      c++;
    end
    repeat (3) tick();
    check({name, "_finish_count"}, fin_cnt - f0, 1);
    check({name, "_output_count"}, exp_n, TOTAL);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish_pool2, 0);
    reset_n = 1'b1;
    tick();

    // 1: ramp back-to-back
    fill_ramp();
    start_run();
    check("t1_busy_run", busy, 1);
    stream(NPIX, 0, -1);
    wait_finish("t1");
    check("t1_out0", got[0], 11);
    check("t1_out1", got[1], 13);
    check("t1_out24", got[24], 99);
    check("t1_out25", got[25], 111);

    // 2: negative map, signed compare
    for (int i = 0; i < NPIX; i++) img[i] = -16'sd5;
    img[0] = -16'sd7; img[1] = -16'sd3; img[10] = -16'sd9; img[11] = -16'sd4;
    start_run();
    stream(NPIX, 0, -1);
    wait_finish("t2");
    check("t2_out0", got[0], -3);
    check("t2_out1", got[1], -5);
    check("t2_out74", got[74], -5);

    // 3: ramp with random in_valid gaps
    fill_ramp();
    start_run();
    stream(NPIX, 30, -1);
    wait_finish("t3");
    check("t3_out0", got[0], 11);
    check("t3_out25", got[25], 111);
    check("t3_out74", got[74], 299);

    // 4: reset mid-run, then a clean full run
    fill_ramp();
    start_run();
    stream(150, 0, -1);
    check("t4_pre_reset_outputs", exp_n, 35);
    reset_n = 1'b0;
    tick();
    check("t4_rst_busy", busy, 0);
    check("t4_rst_out_valid", out_valid, 0);
    check("t4_rst_out_idx", out_idx, 0);
    exp_n   = 0;
    reset_n = 1'b1;
    tick();
    start_run();
    stream(NPIX, 0, -1);
    wait_finish("t4");
    check("t4_out0", got[0], 11);

    // 5: start re-pulsed mid-run, stray beats in IDLE
    fill_ramp();
    start_run();
    stream(NPIX, 0, 150);
    wait_finish("t5");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(1000 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("t5_stray_outputs", exp_n, TOTAL);
    check("t5_stray_busy", busy, 0);

    // 6: tie window at ch2 (0,0)
    fill_ramp();
    img[200] = 16'sd7; img[201] = 16'sd7; img[210] = 16'sd7; img[211] = 16'sd7;
    start_run();
    stream(NPIX, 0, -1);
    wait_finish("t6");
    check("t6_out50", got[50], 7);
    check("t6_out74", got[74], 299);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
